rptr_empty: RTL and testbench

RPTR_EMPTY -- requirements
Module: rptr_empty

---
 rtl/rptr_empty_pkg.sv | 17 +
 rtl/rptr_empty_gray2bin.sv | 17 +
 rtl/rptr_empty.sv | 78 +++++++
 tb/tb_rptr_empty.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rptr_empty_pkg.sv
// rtl/rptr_empty_pkg.sv - shared FIFO pointer defaults and Gray-to-binary helper
package rptr_empty_pkg;

  localparam int DEFAULT_ADDRSIZE = 4;
  localparam int GRAY_FN_WIDTH    = 32;

  // Prefix-XOR Gray decode; callers zero-extend narrower pointers, which leaves the result unchanged
  function automatic logic [GRAY_FN_WIDTH-1:0] gray2bin_f(input logic [GRAY_FN_WIDTH-1:0] gray);
    logic [GRAY_FN_WIDTH-1:0] bin;
    bin[GRAY_FN_WIDTH-1] = gray[GRAY_FN_WIDTH-1];
    for (int i = GRAY_FN_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/rptr_empty_gray2bin.sv
// rtl/rptr_empty_gray2bin.sv - combinational Gray-to-binary prefix-XOR converter
module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      assign bin[i] = ^gray[WIDTH-1:i];
    end
  endgenerate

endmodule

// File: rtl/rptr_empty.sv
// rtl/rptr_empty.sv - async FIFO read pointer, empty/almost-empty and level; optional RPTR_UNDERFLOW_EN
module rptr_empty
  import rptr_empty_pkg::*;
#(
  parameter int ADDRSIZE      = DEFAULT_ADDRSIZE,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE+1)'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] rlevel_next;
  logic              rempty_next;
  logic              ralmost_empty_next;
  logic              pop;

  gray2bin #(.WIDTH(ADDRSIZE+1)) u_wptr_g2b (
    .gray (rq2_wptr),
    .bin  (wbin)
  );

  // Next pointer, next flags and next level; a pop only happens while not empty
  always_comb begin
    pop                = rinc & ~rempty;
    rbinnext           = rbin + {{ADDRSIZE{1'b0}}, pop};
    rgraynext          = (rbinnext >> 1) ^ rbinnext;
    rlevel_next        = wbin - rbinnext;
    rempty_next        = (rgraynext == rq2_wptr);
    ralmost_empty_next = (rlevel_next <= THRESH) | rempty_next;
  end

  // Pointer, flag and level registers, all cleared to the empty state by reset
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      rempty        <= rempty_next;
      ralmost_empty <= ralmost_empty_next;
      rlevel        <= rlevel_next;
    end
  end

  assign raddr = rbin[ADDRSIZE-1:0];

`ifdef RPTR_UNDERFLOW_EN
  // Sticky record of any read attempted against an empty FIFO
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      runderflow <= 1'b0;
    end else if (rinc && rempty) begin
      runderflow <= 1'b1;
    end
  end
`else
  assign runderflow = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// tb/tb_rptr_empty.sv - self-checking bench for rptr_empty with a level-based scoreboard
module tb_rptr_empty;

  localparam int AS = 4;
  localparam int PW = AS + 1;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          rinc = 1'b0;
  logic [PW-1:0] rq2_wptr = '0;
  logic          rempty, ralmost_empty, runderflow;
  logic [AS-1:0] raddr;
  logic [PW-1:0] rptr, rlevel;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic          empty;
    logic          almost;
    logic [AS-1:0] raddr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] rlevel;
    logic          uf;
  } exp_t;

  exp_t sb[$];

  // Bench model state: binary read count, current write count, sticky underflow
  int   m_rbin = 0;
  int   m_wbin = 0;
  logic m_empty = 1'b1;
  logic m_uf = 1'b0;
  logic [PW-1:0] prev_rptr;

  rptr_empty #(.ADDRSIZE(AS), .AEMPTY_THRESH(2)) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .raddr         (raddr),
    .rptr          (rptr),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  always #5 rclk = ~rclk;

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rbin  = 0;
    m_wbin  = 0;
    m_empty = 1'b1;
    m_uf    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rempty"}, 32'(rempty), 32'd1);
    chk({tag, "_ralmost"}, 32'(ralmost_empty), 32'd1);
    chk({tag, "_rptr"}, 32'(rptr), 32'd0);
    chk({tag, "_raddr"}, 32'(raddr), 32'd0);
    chk({tag, "_rlevel"}, 32'(rlevel), 32'd0);
    chk({tag, "_runderflow"}, 32'(runderflow), 32'd0);
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge
  task automatic step(input string tag, input logic inc, input int wcount);
    exp_t e;
    int   lvl;
    logic pop;
    rinc     = inc;
    m_wbin   = wcount % 32;
    rq2_wptr = to_gray(m_wbin);
    pop      = inc && !m_empty;
`ifdef RPTR_UNDERFLOW_EN
    if (inc && m_empty) m_uf = 1'b1;
`endif
    m_rbin   = (m_rbin + (pop ? 1 : 0)) % 32;
    lvl      = (m_wbin - m_rbin + 32) % 32;
    m_empty  = (lvl == 0);
    e.empty  = m_empty;
    e.almost = (lvl <= 2);
    e.raddr  = AS'(m_rbin % 16);
    e.rptr   = to_gray(m_rbin);
    e.rlevel = PW'(lvl);
    e.uf     = m_uf;
    sb.push_back(e);
    @(posedge rclk);
    #1;
    e = sb.pop_front();
    chk({tag, "_rempty"}, 32'(rempty), 32'(e.empty));
    chk({tag, "_ralmost"}, 32'(ralmost_empty), 32'(e.almost));
    chk({tag, "_raddr"}, 32'(raddr), 32'(e.raddr));
    chk({tag, "_rptr"}, 32'(rptr), 32'(e.rptr));
    chk({tag, "_rlevel"}, 32'(rlevel), 32'(e.rlevel));
    chk({tag, "_runderflow"}, 32'(runderflow), 32'(e.uf));
  endtask

  initial begin
    // Reset held low: outputs at their empty state
    #12;
    check_reset_outputs("reset");
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    model_reset();

    // Read while empty: no movement; underflow only when the feature is built in
    step("empty_rd0", 1'b1, 0);
    step("empty_rd1", 1'b1, 0);

    // Five entries appear, then five pops drain the FIFO
    step("w5", 1'b0, 5);
    for (int i = 0; i < 5; i++) step($sformatf("pop5_%0d", i), 1'b1, 5);
    chk("pop5_rptr_final", 32'(rptr), 32'h07);
    chk("pop5_level_final", 32'(rlevel), 32'd0);

    // Underflow stays sticky across later writes and reads
    step("after_w", 1'b0, 7);
    step("after_r", 1'b1, 7);

    // Asynchronous reset mid-operation clears everything without a clock edge
    #2;
    rrst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    model_reset();
    rq2_wptr = '0;
    rinc = 1'b0;

    // Wrap: 40 interleaved writes and pops; Gray pointer moves one bit per pop
    for (int i = 0; i < 40; i++) begin
      step($sformatf("wrap_w%0d", i), 1'b0, i + 1);
      prev_rptr = rptr;
      step($sformatf("wrap_p%0d", i), 1'b1, i + 1);
      chk($sformatf("wrap_onebit%0d", i), 32'($countones(prev_rptr ^ rptr)), 32'd1);
      if (i == 15 || i == 31) chk($sformatf("wrap_msb%0d", i), 32'(rptr[PW-1]), (i == 15) ? 32'd1 : 32'd0);
    end

    // Full level: sixteen entries ahead of a zero read pointer
    rrst_n = 1'b0;
    #1;
    rrst_n = 1'b1;
    model_reset();
    step("full", 1'b0, 16);
    chk("full_level", 32'(rlevel), 32'd16);
    step("full_pop", 1'b1, 16);

    // Same-cycle write and pop at level 1 keeps the FIFO non-empty
    rrst_n = 1'b0;
    #1;
    rrst_n = 1'b1;
    model_reset();
    step("same_l1", 1'b0, 1);
    step("same_evt", 1'b1, 2);
    chk("same_rempty", 32'(rempty), 32'd0);
    chk("same_rlevel", 32'(rlevel), 32'd1);
    step("same_drain", 1'b1, 2);

    rinc = 1'b0;
    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
